range_sweep: RTL and testbench

//   Sequential generator of values in the half-open range [LOWER_BOUND, UPPER_BOUND).

---
 rtl/range_sweep.sv | 141 ++++++++++++++
 tb/tb_range_sweep.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/range_sweep.sv
// range_sweep: valid/ready value generator over [LOWER_BOUND, UPPER_BOUND).
// Define RANGE_SWEEP_CHECK_EN to build the embedded range checker driving err.
module range_sweep #(
  parameter int WIDTH       = 7,
  parameter int LOWER_BOUND = 85,
  parameter int UPPER_BOUND = 120,
  parameter int STEP_W      = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              stop,
  input  logic              continuous,
  input  logic [STEP_W-1:0] step,
  output logic [WIDTH-1:0]  dout,
  output logic              dout_valid,
  input  logic              dout_ready,
  output logic              busy,
  output logic              wrap,
  output logic              done,
  output logic              err
);

  localparam int SUM_W =
    ((WIDTH > STEP_W) ? WIDTH : STEP_W) + 1;
  localparam logic [WIDTH-1:0] LO =
    WIDTH'(LOWER_BOUND);
  localparam logic [SUM_W-1:0] HI =
    SUM_W'(UPPER_BOUND);

  if (LOWER_BOUND >= UPPER_BOUND ||
      UPPER_BOUND > 2**WIDTH) begin : g_bad_bounds
    $error("range_sweep: illegal LOWER/UPPER bounds");
  end

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t            state;
  logic [STEP_W-1:0] step_q;
  logic              cont_q;
  logic              stop_pend;

  logic [SUM_W-1:0]  nxt;
  logic              xfer;
  logic              at_top;
  logic              end_req;

  // Sum is one bit wider than either operand so it never overflows.
  always_comb begin
    xfer    = dout_valid & dout_ready;
    nxt     = SUM_W'(dout) + SUM_W'(step_q);
    at_top  = (nxt >= HI);
    end_req = stop_pend | stop;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      dout       <= LO;
      dout_valid <= 1'b0;
      busy       <= 1'b0;
      wrap       <= 1'b0;
      done       <= 1'b0;
      step_q     <= STEP_W'(1);
      cont_q     <= 1'b0;
      stop_pend  <= 1'b0;
    end else begin
      wrap <= 1'b0;
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            step_q     <= (step == '0) ?
                          STEP_W'(1) : step;
            cont_q     <= continuous;
            dout       <= LO;
            dout_valid <= 1'b1;
            busy       <= 1'b1;
            stop_pend  <= 1'b0;
            state      <= RUN;
          end
        end
        RUN: begin
          if (stop)
            stop_pend <= 1'b1;
          if (xfer) begin
            unique case (1'b1)
              end_req: begin
                dout_valid <= 1'b0;
                busy       <= 1'b0;
                done       <= 1'b1;
                stop_pend  <= 1'b0;
                state      <= IDLE;
              end
              (!end_req && at_top && cont_q): begin
                dout <= LO;
                wrap <= 1'b1;
              end
              (!end_req && at_top && !cont_q): begin
                dout_valid <= 1'b0;
                busy       <= 1'b0;
                done       <= 1'b1;
                stop_pend  <= 1'b0;
                state      <= IDLE;
              end
              default: begin
                dout <= nxt[WIDTH-1:0];
              end
            endcase
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

`ifdef RANGE_SWEEP_CHECK_EN
  logic oob;

  always_comb begin
    oob = dout_valid &&
          ((dout < LO) || (SUM_W'(dout) >= HI));
  end

  // Sticky until reset: one bad beat is enough to flag the path.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      err <= 1'b0;
    else if (oob)
      err <= 1'b1;
  end
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_range_sweep.sv
// tb_range_sweep: directed bench with a transfer-list model of range_sweep.
// Expected beats are queued per sweep and checked on every negedge.
module tb_range_sweep;

  localparam int W  = 7;
  localparam int LB = 85;
  localparam int UB = 120;
  localparam int SW = 4;

  logic          clk;
  logic          rst_n;
  logic          start;
  logic          stop;
  logic          continuous;
  logic [SW-1:0] step;
  logic [W-1:0]  dout;
  logic          dout_valid;
  logic          dout_ready;
  logic          busy;
  logic          wrap;
  logic          done;
  logic          err;

  range_sweep #(
    .WIDTH(W), .LOWER_BOUND(LB),
    .UPPER_BOUND(UB), .STEP_W(SW)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .start(start), .stop(stop),
    .continuous(continuous), .step(step),
    .dout(dout), .dout_valid(dout_valid),
    .dout_ready(dout_ready), .busy(busy),
    .wrap(wrap), .done(done), .err(err)
  );

  typedef struct {
    int val;
    bit w;
    bit d;
  } exp_t;

  exp_t exp_q[$];
  exp_t plan[$];
  exp_t e;
  bit   exp_w;
  bit   exp_d;
  int   n_cmp;
  int   n_err;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(string nm, int act, int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d",
               nm, act, exp);
    end
  endtask

  task automatic fail_now(string nm);
    n_cmp++;
    n_err++;
    $display("FAIL %s", nm);
  endtask

  // Expected transfers from the sweep rules, independent of any FSM.
  task automatic build_plan(int s, bit cont, int n);
    int se;
    int v;
    int nx;
    bit last;
    exp_t x;
    plan.delete();
    se = (s == 0) ? 1 : s;
    v  = LB;
    for (int i = 0; i < 1000; i++) begin
      nx = v + se;
      if (!cont) begin
        last  = (nx >= UB);
        x.val = v; x.w = 1'b0; x.d = last;
        plan.push_back(x);
        if (last) break;
        v = nx;
      end else begin
        last  = (i == n - 1);
        x.val = v;
        x.w   = !last && (nx >= UB);
        x.d   = last;
        plan.push_back(x);
        if (last) break;
        v = (nx >= UB) ? LB : nx;
      end
    end
  endtask

  task automatic launch(int s, bit cont);
    exp_q      = plan;
    start      = 1'b1;
    step       = SW'(s);
    continuous = cont;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic drain(int budget, bit stop_last);
    for (int i = 0; i < budget; i++) begin
      if (exp_q.size() == 0) break;
      stop = stop_last && (exp_q.size() == 1);
      @(posedge clk); #1;
    end
    stop = 1'b0;
    if (exp_q.size() != 0) begin
      fail_now("drain_timeout");
      exp_q.delete();
    end
    @(negedge clk);
    @(posedge clk); #1;
  endtask

  task automatic wait_val(int v, int budget);
    bit hit;
    hit = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (dout_valid && int'(dout) == v) begin
        hit = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    if (!hit) fail_now("wait_val_timeout");
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      exp_w = 1'b0;
      exp_d = 1'b0;
    end else begin
      chk("err", int'(err), 0);
      chk("wrap", int'(wrap), int'(exp_w));
      chk("done", int'(done), int'(exp_d));
      if (exp_d) begin
        chk("valid_after_done", int'(dout_valid), 0);
        chk("busy_after_done", int'(busy), 0);
      end
      exp_w = 1'b0;
      exp_d = 1'b0;
      if (dout_valid) begin
        chk("busy", int'(busy), 1);
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL extra_valid: dout %0d, none expected",
                   dout);
        end else begin
          chk("dout", int'(dout), exp_q[0].val);
          if (dout_ready) begin
            e     = exp_q.pop_front();
            exp_w = e.w;
            exp_d = e.d;
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    n_cmp      = 0;
    n_err      = 0;
    rst_n      = 1'b0;
    start      = 1'b0;
    stop       = 1'b0;
    continuous = 1'b0;
    step       = '0;
    dout_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_dout", int'(dout), 85);
    chk("rst_valid", int'(dout_valid), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_wrap", int'(wrap), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_err", int'(err), 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // 1: one-shot step 5, stop in IDLE ignored
    stop = 1'b1;
    @(posedge clk); #1;
    stop = 1'b0;
    chk("idle_stop_valid", int'(dout_valid), 0);
    build_plan(5, 1'b0, 0);
    chk("pin_t1_len", plan.size(), 7);
    chk("pin_t1_last", plan[6].val, 115);
    launch(5, 1'b0);
    chk("t1_first", int'(dout), 85);
    chk("t1_first_valid", int'(dout_valid), 1);
    drain(50, 1'b0);
    chk("t1_idle_busy", int'(busy), 0);

    // 2: continuous step 15, stop on the 7th beat
    build_plan(15, 1'b1, 7);
    chk("pin_t2_top", plan[2].val, 115);
    chk("pin_t2_wrap", int'(plan[2].w), 1);
    chk("pin_t2_back", plan[3].val, 85);
    launch(15, 1'b1);
    drain(50, 1'b1);

    // 3: step 0 behaves as 1; start in RUN ignored
    build_plan(0, 1'b0, 0);
    chk("pin_t3_len", plan.size(), 35);
    chk("pin_t3_last", plan[34].val, 119);
    launch(0, 1'b0);
    start = 1'b1;
    step  = SW'(3);
    @(posedge clk); #1;
    start = 1'b0;
    drain(100, 1'b0);

    // 4: backpressure holds 90 for 3 cycles
    build_plan(5, 1'b0, 0);
    launch(5, 1'b0);
    wait_val(90, 10);
    dout_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("t4_hold_dout", int'(dout), 90);
      chk("t4_hold_valid", int'(dout_valid), 1);
    end
    @(posedge clk); #1;
    dout_ready = 1'b1;
    drain(50, 1'b0);

    // 5: stop while 100 is stalled
    build_plan(5, 1'b0, 0);
    while (plan.size() > 4) void'(plan.pop_back());
    plan[3].d = 1'b1;
    chk("pin_t5_last", plan[3].val, 100);
    launch(5, 1'b0);
    wait_val(100, 10);
    dout_ready = 1'b0;
    stop       = 1'b1;
    @(posedge clk); #1;
    stop = 1'b0;
    @(posedge clk); #1;
    dout_ready = 1'b1;
    drain(20, 1'b0);
    repeat (3) @(posedge clk);
    #1;

    // 6: async reset mid-sweep
    build_plan(15, 1'b1, 100);
    launch(15, 1'b1);
    wait_val(100, 10);
    rst_n = 1'b0;
    #1;
    exp_q.delete();
    chk("t6_valid", int'(dout_valid), 0);
    chk("t6_dout", int'(dout), 85);
    chk("t6_busy", int'(busy), 0);
    repeat (2) @(posedge clk);
    #1;
    chk("t6_done", int'(done), 0);
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("t6_after_valid", int'(dout_valid), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
